// File: rtl/layer_sequencer_pkg.sv
// Shared helpers for layer_sequencer: derived-dimension and counter/address width functions.
package layer_sequencer_pkg;

  localparam int unsigned TREE_CYCLES = 2;

  // Width of a counter that must reach n-1; at least one bit so n==1 still elaborates
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned conv_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_counter.sv
// Two-level wrap counter: inner runs 0..INNER_N-1, outer steps on inner wrap, wrap pulses at the final count.
module nested_counter
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned OUTER_N = 2,
  parameter int unsigned INNER_N = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic [cnt_w(OUTER_N)-1:0]   outer,
  output logic [cnt_w(INNER_N)-1:0]   inner,
  output logic                        wrap
);

  localparam int unsigned OW_ = cnt_w(OUTER_N);
  localparam int unsigned IW_ = cnt_w(INNER_N);

  logic inner_last;
  logic outer_last;

  assign inner_last = (inner == IW_'(INNER_N - 1));
  assign outer_last = (outer == OW_'(OUTER_N - 1));
  assign wrap       = en & inner_last & outer_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner <= '0;
      outer <= '0;
    end else if (en) begin
      if (inner_last) begin
        inner <= '0;
        outer <= outer_last ? '0 : outer + OW_'(1);
      end else begin
        inner <= inner + IW_'(1);
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Responder side of the layer-controller handshake: owns the per-layer counters and drives ROM/buffer addresses.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned IC     = 0,
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned K      = 3,
  parameter int unsigned NUM_OC = 4,
  parameter int unsigned POOL_S = 2,
  localparam int unsigned OW       = conv_dim(IMG_W, K),
  localparam int unsigned OH       = conv_dim(IMG_H, K),
  localparam int unsigned PW       = OW / POOL_S,
  localparam int unsigned PH       = OH / POOL_S,
  localparam int unsigned LOAD_LEN = K * K * NUM_CH,
  localparam int unsigned WT_AW    = addr_w(NUM_OC * LOAD_LEN),
  localparam int unsigned CB_AW    = addr_w(NUM_OC * OW * OH),
  localparam int unsigned PL_AW    = addr_w(NUM_OC * PW * PH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_load,
  input  logic             conv,
  input  logic             tree,
  input  logic             cout,
  input  logic             pool,
  output logic             c_load_done,
  output logic             conv_done,
  output logic             cout_done,
  output logic             pool_done,
  output logic             wt_rd_en,
  output logic [WT_AW-1:0] wt_addr,
  output logic             cbuf_wr_en,
  output logic [CB_AW-1:0] cbuf_wr_addr,
  output logic             cbuf_rd_en,
  output logic [CB_AW-1:0] cbuf_rd_addr,
  output logic             pool_first,
  output logic             pool_wr_en,
  output logic [PL_AW-1:0] pool_wr_addr
);

  localparam int unsigned LDW = cnt_w(LOAD_LEN);
  localparam int unsigned OCW = cnt_w(NUM_OC);

  logic [LDW-1:0]            ld_cnt;
  logic [OCW-1:0]            oc_cnt;
  logic [OCW-1:0]            pc;
  logic [cnt_w(OH)-1:0]      row;
  logic [cnt_w(OW)-1:0]      col;
  logic [cnt_w(PH)-1:0]      pr;
  logic [cnt_w(PW)-1:0]      pcol;
  logic [cnt_w(POOL_S)-1:0]  dr;
  logic [cnt_w(POOL_S)-1:0]  dc;
  logic                      tree_phase;
  logic                      conv_step;
  logic                      win_wrap;
  logic                      pos_wrap;
  logic                      oc_last;
  logic                      pc_last;

  // Weight load
  assign wt_rd_en    = c_load;
  assign c_load_done = c_load & (ld_cnt == LDW'(LOAD_LEN - 1));
  assign wt_addr     = WT_AW'(32'(oc_cnt) * LOAD_LEN + 32'(ld_cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ld_cnt <= '0;
    else if (c_load_done) ld_cnt <= '0;
    else if (c_load)      ld_cnt <= ld_cnt + LDW'(1);
  end

  // Output channel
  assign oc_last   = (oc_cnt == OCW'(NUM_OC - 1));
  assign cout_done = cout & oc_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         oc_cnt <= '0;
    else if (cout_done) oc_cnt <= '0;
    else if (cout)      oc_cnt <= oc_cnt + OCW'(1);
  end

  // With an adder tree the position only commits on the second tree cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tree_phase <= 1'b0;
    else        tree_phase <= tree ? ~tree_phase : 1'b0;
  end

  assign conv_step  = (IC == 0) ? conv : (tree & tree_phase);
  assign cbuf_wr_en = conv_step;

  nested_counter #(.OUTER_N(OH), .INNER_N(OW)) u_conv_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (conv_step),
    .outer (row),
    .inner (col),
    .wrap  (conv_done)
  );

  assign cbuf_wr_addr = CB_AW'(32'(oc_cnt) * OW * OH + 32'(row) * OW + 32'(col));

  // Pool: window (dr,dc) innermost, then position (pr,pcol), then channel pc
  nested_counter #(.OUTER_N(POOL_S), .INNER_N(POOL_S)) u_pool_win (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pool),
    .outer (dr),
    .inner (dc),
    .wrap  (win_wrap)
  );

  nested_counter #(.OUTER_N(PH), .INNER_N(PW)) u_pool_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (win_wrap),
    .outer (pr),
    .inner (pcol),
    .wrap  (pos_wrap)
  );

  assign pc_last = (pc == OCW'(NUM_OC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= '0;
    else if (pos_wrap) pc <= pc_last ? '0 : pc + OCW'(1);
  end

  assign cbuf_rd_en   = pool;
  assign pool_first   = pool & (dr == '0) & (dc == '0);
  assign pool_wr_en   = win_wrap;
  assign pool_done    = pos_wrap & pc_last;
  assign cbuf_rd_addr = CB_AW'(32'(pc) * OW * OH + (32'(pr) * POOL_S + 32'(dr)) * OW
                               + 32'(pcol) * POOL_S + 32'(dc));
  assign pool_wr_addr = PL_AW'(32'(pc) * PW * PH + 32'(pr) * PW + 32'(pcol));

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Responder side of the layer controller handshake. Takes the level strobes c_load, conv, tree, cout and pool, and returns c_load_done, conv_done, cout_done and pool_done.
- Owns every per-layer counter: weight-load word, conv output position, output channel, pool window. From these it drives the weight-ROM, conv-buffer and pool-buffer addresses and enables.
- One instance per conv layer, placed beside the layer's controller.

Parameters:
- IC, 0, input-channel mode; 0 = single-channel conv, no adder tree; >0 = each conv position is followed by a 2-cycle tree phase.
- NUM_CH, 1, input channels whose kernels are loaded per output channel.
- IMG_W, 28, input feature-map width.
- IMG_H, 28, input feature-map height.
- K, 3, square kernel size.
- NUM_OC, 4, output channels.
- POOL_S, 2, square pooling window and stride. OW = IMG_W-K+1 and OH = IMG_H-K+1 must both be multiples of POOL_S.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- c_load  in  1  weight-load strobe; held high across the load
- conv  in  1  conv strobe
- tree  in  1  adder-tree strobe; high for exactly 2 consecutive cycles per position
- cout  in  1  output-channel advance strobe; 1 cycle
- pool  in  1  pool strobe; held high across the pool pass
- c_load_done  out  1  last weight word this cycle
- conv_done  out  1  last conv position completes this cycle
- cout_done  out  1  last output channel completes this cycle
- pool_done  out  1  last pool read this cycle
- wt_rd_en  out  1  weight-ROM read enable
- wt_addr  out  $clog2(NUM_OC*K*K*NUM_CH)  weight-ROM address
- cbuf_wr_en  out  1  conv-buffer write enable
- cbuf_wr_addr  out  $clog2(NUM_OC*OW*OH)  conv-buffer write address
- cbuf_rd_en  out  1  conv-buffer read enable (pooling)
- cbuf_rd_addr  out  $clog2(NUM_OC*OW*OH)  conv-buffer read address
- pool_first  out  1  first element of a pool window (max register reload)
- pool_wr_en  out  1  last element of a pool window (result write)
- pool_wr_addr  out  $clog2(NUM_OC*(OW/POOL_S)*(OH/POOL_S))  pooled-output address

Behaviour:
- **Reset.** Every counter, tree_phase and last-state flop clears to 0. All done signals and enables are combinational, gated by the input strobes, so they read 0 while strobes are low. An rst_n assertion mid-pass aborts it; the next pass restarts at 0.
- **Registered state:**
  - ld_cnt: 0..K*K*NUM_CH-1
  - row/col: conv position
  - oc_cnt: 0..NUM_OC-1
  - pool counters: pc, pr, pcol, dr, dc
  - tree_phase
- **Weight load** (each c_load cycle):
  - wt_rd_en = c_load.
  - wt_addr = oc_cnt*K*K*NUM_CH + ld_cnt.
  - c_load_done = c_load & (ld_cnt == K*K*NUM_CH-1).
  - ld_cnt increments each c_load cycle and wraps to 0 on c_load_done.
- **Conv, IC==0:**
  - Each conv cycle, cbuf_wr_en = 1 and cbuf_wr_addr = oc_cnt*OW*OH + row*OW + col.
  - col advances every conv cycle; at OW-1 it wraps and row increments.
  - conv_done = conv & (row==OH-1) & (col==OW-1); row and col wrap to 0 on that cycle.
- **Conv, IC>0:**
  - conv cycles only present data; the position does not advance.
  - tree_phase <= tree ? ~tree_phase : 0.
  - On tree & tree_phase (the 2nd tree cycle): cbuf_wr_en = 1 at the current position, then the position advances.
  - conv_done = tree & tree_phase & last position. It is low on conv cycles.
- **Output channel:**
  - cout_done = cout & (oc_cnt == NUM_OC-1).
  - oc_cnt increments on cout and wraps to 0 on cout_done.
- **Pool** (one conv-buffer read per pool cycle):
  - Loop order, innermost first: dc, dr, pcol, pr, pc.
  - cbuf_rd_addr = pc*OW*OH + (pr*POOL_S+dr)*OW + (pcol*POOL_S+dc).
  - pool_first = pool & dr==0 & dc==0.
  - pool_wr_en = pool & dr==POOL_S-1 & dc==POOL_S-1.
  - pool_wr_addr = pc*PW*PH + pr*PW + pcol, where PW = OW/POOL_S and PH = OH/POOL_S.
  - pool_done = pool_wr_en & last pc/pr/pcol. All pool counters wrap to 0 on that cycle.
- **Boundaries:**
  - A strobe dropping mid-count holds its counter. No implicit clear except reset or the wrap at done.
  - Strobes are independent. If several are high together, each counter acts on its own strobe; no priority logic.
- **Arithmetic.** Addresses are computed from the counters with constant multipliers, unsigned, truncated to the port width. No output registers: each address is valid in the same cycle as its enable.

Decomposition:
- Shared package: derived constants OW, OH, PW, PH, LOAD_LEN = K*K*NUM_CH, and the address-width localparams.
- One natural sub-module: nested_counter. It is a parameterised 2-D wrap counter with inputs en, limits and wrap flag, reused for conv row/col and the pool window/position loops.

Test Plan:
All scenarios use IMG_W=IMG_H=6, K=3, NUM_CH=1, NUM_OC=2, POOL_S=2, so OW=OH=4 and PW=PH=2.
1. **Load:** c_load high 9 cycles → wt_addr 0..8, c_load_done only in cycle 9. After cout, next load wt_addr 9..17.
2. **Conv, IC=0:** conv high 16 cycles → cbuf_wr_addr 0..15, conv_done only on cycle 16. A second pass after cout gives addresses 16..31.
3. **Conv, IC=2:** repeat conv, tree, tree 16 times → cbuf_wr_en only on 2nd tree cycles, addresses 0..15, conv_done on the 48th cycle only.
4. **Cout:** first cout → cout_done=0. Second cout → cout_done=1, then oc_cnt=0.
5. **Pool:** pool held 32 cycles → first reads 0,1,4,5 with pool_wr_addr 0. pool_wr_en every 4th cycle. pool_done at cycle 32 with pool_wr_addr 7 and read addr 31.
6. **Reset:** rst_n low at conv cycle 7 → next pass starts at cbuf_wr_addr 0, all done signals low.
